// File: rtl/mem_in_packer.sv
// Packs narrow input beats into wide SRAM words, issuing sequential word writes
// with lane strobes and a per-packet word-count report.
module mem_in_packer #(
    parameter int IN_W      = 8,
    parameter int PACK_N    = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_last,
    output logic                     mem_wr_en,
    input  logic                     mem_wr_ready,
    output logic [ADDR_W-1:0]        mem_wr_addr,
    output logic [IN_W*PACK_N-1:0]   mem_wr_data,
    output logic [PACK_N-1:0]        mem_wr_strb,
    output logic                     pkt_done,
    output logic [ADDR_W:0]          pkt_words
);

    localparam int LC_W = $clog2(PACK_N);
    localparam logic [LC_W-1:0]   LAST_LANE = LC_W'(PACK_N - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    logic [PACK_N-1:0][IN_W-1:0] acc;
    logic [PACK_N-1:0][IN_W-1:0] word_nxt;
    logic [PACK_N-1:0]           strb_nxt;
    logic [LC_W-1:0]             lane_cnt;
    logic [ADDR_W:0]             word_cnt;
    logic                        last_q;
    logic                        accept;
    logic                        complete;
    logic                        wr_acc;

    // A stalled pending write is the only reason to refuse a beat.
    assign in_ready = rst_n && !(mem_wr_en && !mem_wr_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((lane_cnt == LAST_LANE) || in_last);
    assign wr_acc   = mem_wr_en && mem_wr_ready;

    // Word as it would look if the current beat closed it; lanes past the beat read as 0.
    always_comb begin
        word_nxt = '0;
        strb_nxt = '0;
        for (int k = 0; k < PACK_N; k++) begin
            if (LC_W'(k) < lane_cnt) begin
                word_nxt[k] = acc[k];
                strb_nxt[k] = 1'b1;
            end else if (LC_W'(k) == lane_cnt) begin
                word_nxt[k] = in_data;
                strb_nxt[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= '0;
            lane_cnt    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= BASE;
            mem_wr_data <= '0;
            mem_wr_strb <= '0;
            last_q      <= 1'b0;
            word_cnt    <= '0;
            pkt_done    <= 1'b0;
            pkt_words   <= '0;
        end else begin
            if (complete) begin
                mem_wr_data <= word_nxt;
                mem_wr_strb <= strb_nxt;
                last_q      <= in_last;
                mem_wr_en   <= 1'b1;
                acc         <= '0;
                lane_cnt    <= '0;
            end else begin
                if (accept) begin
                    acc[lane_cnt] <= in_data;
                    lane_cnt      <= lane_cnt + 1'b1;
                end
                if (wr_acc)
                    mem_wr_en <= 1'b0;
            end

            // Address wraps silently and persists across packets.
            pkt_done <= wr_acc && last_q;
            if (wr_acc) begin
                mem_wr_addr <= mem_wr_addr + 1'b1;
                if (last_q) begin
                    pkt_words <= word_cnt + 1'b1;
                    word_cnt  <= '0;
                end else begin
                    word_cnt  <= word_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mem_in_packer.md
# mem_in_packer

Packs the narrow beat stream of the memory-input interface (the stream driven by the Mem_in agent) into wide memory words and issues them as sequential writes to a word-addressed SRAM port. It sits directly downstream of the Mem_in interface and upstream of the memory write port. It also handles packet boundaries, partial-word strobes, write-address generation and a per-packet completion report.

## Interface
Parameters:
- IN_W, default 8: input beat width in bits.
- PACK_N, default 4: beats per memory word; must be ≥2. Memory word width is IN_W*PACK_N.
- ADDR_W, default 10: memory word-address width.
- BASE_ADDR, default 0: write address loaded at reset.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: an input beat is present.
- in_ready, output, 1: the block accepts the beat this cycle.
- in_data, input, IN_W: beat payload.
- in_last, input, 1: the beat is the final beat of a packet.
- mem_wr_en, output, 1: a write request is pending; held until accepted.
- mem_wr_ready, input, 1: the memory accepts the write this cycle.
- mem_wr_addr, output, ADDR_W: word address of the pending write.
- mem_wr_data, output, IN_W*PACK_N: packed word. Lane k is bits [k*IN_W +: IN_W].
- mem_wr_strb, output, PACK_N: lane-valid mask of the pending write.
- pkt_done, output, 1: one-cycle pulse reporting packet completion.
- pkt_words, output, ADDR_W+1: number of words in the completed packet. Valid only while pkt_done is 1.

## Operation
- Handshakes:
  - An input beat is accepted when in_valid && in_ready.
  - A write is accepted when mem_wr_en && mem_wr_ready.
- in_ready = rst_n && !(mem_wr_en && !mem_wr_ready). This is combinational from mem_wr_ready; there is no other input-side stall.
- Accumulator:
  - Holds PACK_N lanes and a lane counter lane_cnt (0..PACK_N-1).
  - An accepted beat writes lane[lane_cnt].
- Word completion: a word is complete when the accepted beat has lane_cnt==PACK_N-1 or in_last=1.
- On word completion, the next clock does all of the following:
  - Loads the output register with the word and its last flag.
  - Sets mem_wr_data to the accumulator lanes plus the new beat. Unfilled lanes are forced to 0.
  - Sets mem_wr_strb to the filled lanes, which are contiguous from lane 0. For example, 3 beats with PACK_N=4 gives 4'b0111.
  - Sets mem_wr_en to 1.
  - Clears lane_cnt and the accumulator.
- Otherwise an accepted beat increments lane_cnt.
- Output register:
  - mem_wr_en, mem_wr_addr, mem_wr_data and mem_wr_strb are held stable while mem_wr_en && !mem_wr_ready.
  - On write acceptance with no new word completing in the same cycle, mem_wr_en falls next cycle.
  - On write acceptance with a word completing in the same cycle, the register reloads and mem_wr_en stays 1.
- Address generation:
  - mem_wr_addr increments by 1 on each write acceptance.
  - It wraps from 2^ADDR_W-1 to 0. Wrap is silent, with no flag.
  - The address is not reset between packets.
- Packet accounting:
  - word_cnt increments on each write acceptance.
  - When the accepted write carries the last flag, the next cycle drives pkt_done=1 and pkt_words=word_cnt+1, and word_cnt clears.
  - A single-beat packet produces pkt_words=1 with strobe 'b0001.
- in_valid=0 between beats of a packet is legal. The partial accumulator is retained indefinitely.

## Timing
- Reset values, forced while rst_n=0 at the clock edge:
  - mem_wr_en=0, mem_wr_addr=BASE_ADDR, mem_wr_data=0, mem_wr_strb=0.
  - pkt_done=0, pkt_words=0, lane_cnt=0, word_cnt=0, accumulator=0.
  - in_ready=0 while rst_n=0.
- Reset mid-packet discards the partial accumulator and any pending write with no pkt_done. The first cycle after release has in_ready=1.
- Latency: a word-completing beat accepted in cycle t gives mem_wr_en=1 in cycle t+1. A last-word write accepted in cycle t gives pkt_done=1 in cycle t+1.
- Throughput: with mem_wr_ready held at 1, the block accepts one beat per cycle with no bubbles. This includes back-to-back packets and consecutive single-beat packets.
- Backpressure: if mem_wr_ready=0 while mem_wr_en=1, in_ready=0 in that same cycle. No beat is accepted, so no word is ever dropped or overwritten.
- pkt_done is exactly one cycle wide. Consecutive packets may produce pulses in consecutive cycles.

## Test plan
All scenarios use IN_W=8, PACK_N=4, ADDR_W=10, BASE_ADDR=0.
- Full packet:
  - Stimulus: 8 beats 0x01..0x08, last on 0x08, mem_wr_ready=1.
  - Required: writes addr0=0x04030201 strb 4'hF, then addr1=0x08070605 strb 4'hF; pkt_done one cycle after the second write with pkt_words=2.
- Partial tail:
  - Stimulus: 6 beats 0xA0..0xA5, last on 0xA5.
  - Required: second write is 0x0000A5A4 strb 4'b0011; pkt_words=2.
- Backpressure:
  - Stimulus: mem_wr_ready=0 for 5 cycles while the first word is pending.
  - Required: in_ready=0 for those 5 cycles; addr, data and strb held; no beat lost; final data matches the no-stall run.
- Address wrap:
  - Stimulus: stream 1025 full words.
  - Required: the 1025th word is written at addr 0 after addr 1023.
- Single-beat packets back-to-back:
  - Stimulus: beats 0x11(last), 0x22(last), 0x33(last).
  - Required: three writes with strb 4'b0001 on consecutive cycles; three consecutive pkt_done pulses, each with pkt_words=1.
- Mid-packet reset:
  - Stimulus: assert rst_n=0 after 2 beats of a packet.
  - Required: no write and no pkt_done; the next packet starts at lane 0 with addr=0.
